// File: rtl/cache_l2_assoc.sv
// cache_l2_assoc: write-back, write-allocate, set-associative cache with
// true-LRU replacement and a write-back-all flush command.
// One word per line. The address is split into index (low IDX_W bits) and tag.
//
// Ports:
//   clk, reset                 - single clock, synchronous active-low reset
//   req_*                      - core request channel (valid/ready handshake)
//   resp_valid/hit/rdata       - single-cycle response, no backpressure
//   mem_req_* / mem_we/addr/wdata - backing-memory request (valid/ready)
//   mem_resp_valid, mem_rdata  - backing-memory read return
//   flush, flush_done          - write back all dirty lines / completion pulse
//   hit_cnt, miss_cnt          - wrapping performance counters
module cache_l2_assoc #(
    parameter int WAYS   = 2,
    parameter int SETS   = 512,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              flush,
    output logic              flush_done,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);
    localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WB, S_REFILL_REQ, S_REFILL_WAIT, S_FL_SCAN, S_FL_WB
    } state_t;

    // Line storage. valid/dirty/age are reset; tag/data are don't-care while invalid.
    logic [SETS-1:0][WAYS-1:0]            valid_q, dirty_q;
    logic [SETS-1:0][WAYS-1:0][WAY_W-1:0] age_q;
    logic [TAG_W-1:0]                     tag_q  [SETS][WAYS];
    logic [DATA_W-1:0]                    data_q [SETS][WAYS];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, mem_wdata_q, mem_wdata_d;
    logic              we_q, we_d, mem_we_q, mem_we_d, flush_done_q, flush_done_d;
    logic [WAY_W-1:0]  vict_q, vict_d, fl_way_q, fl_way_d;
    logic [IDX_W-1:0]  fl_set_q, fl_set_d;
    logic [31:0]       hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    // Single line-update port shared by hit, install and flush-clean.
    logic              upd_en, upd_dirty, lru_en;
    logic [IDX_W-1:0]  upd_set;
    logic [WAY_W-1:0]  upd_way, lru_old;
    logic [TAG_W-1:0]  upd_tag;
    logic [DATA_W-1:0] upd_data;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hit, inv_found, fl_last;
    logic [WAY_W-1:0]  hit_way, inv_way, old_way, victim;

    assign idx     = addr_q[IDX_W-1:0];
    assign tag     = addr_q[ADDR_W-1:IDX_W];
    assign fl_last = (fl_set_q == LAST_SET) && (fl_way_q == LAST_WAY);
    assign lru_old = age_q[upd_set][upd_way];

    // Tag match plus victim choice: lowest invalid way, else the oldest way.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        old_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
            if (age_q[idx][w] == LAST_WAY) old_way = WAY_W'(w);
        end
        victim = inv_found ? inv_way : old_way;
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        vict_d       = vict_q;
        fl_set_d     = fl_set_q;
        fl_way_d     = fl_way_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        flush_done_d = 1'b0;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        upd_en       = 1'b0;
        upd_set      = idx;
        upd_way      = vict_q;
        upd_dirty    = 1'b0;
        upd_tag      = tag;
        upd_data     = wdata_q;
        lru_en       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d  = S_FL_SCAN;
                    fl_set_d = '0;
                    fl_way_d = '0;
                end else if (req_valid) begin
                    state_d = S_LOOKUP;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    we_d    = req_we;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    hit_cnt_d = hit_cnt_q + 32'd1;
                    upd_en    = 1'b1;
                    lru_en    = 1'b1;
                    upd_way   = hit_way;
                    upd_dirty = we_q | dirty_q[idx][hit_way];
                    upd_data  = we_q ? wdata_q : data_q[idx][hit_way];
                    state_d   = S_IDLE;
                end else begin
                    miss_cnt_d = miss_cnt_q + 32'd1;
                    vict_d     = victim;
                    if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {tag_q[idx][victim], idx};
                        mem_wdata_d = data_q[idx][victim];
                        state_d     = S_WB;
                    end else begin
                        mem_we_d   = 1'b0;
                        mem_addr_d = addr_q;
                        state_d    = S_REFILL_REQ;
                    end
                end
            end
            S_WB: begin
                if (mem_req_ready) begin
                    mem_we_d   = 1'b0;
                    mem_addr_d = addr_q;
                    state_d    = S_REFILL_REQ;
                end
            end
            S_REFILL_REQ: begin
                if (mem_req_ready) state_d = S_REFILL_WAIT;
            end
            S_REFILL_WAIT: begin
                if (mem_resp_valid) begin
                    upd_en    = 1'b1;
                    lru_en    = 1'b1;
                    upd_dirty = we_q;
                    upd_data  = we_q ? wdata_q : mem_rdata;
                    state_d   = S_IDLE;
                end
            end
            S_FL_SCAN, S_FL_WB: begin
                // FL_SCAN inspects one line per cycle; FL_WB waits for its write.
                if (state_q == S_FL_SCAN && valid_q[fl_set_q][fl_way_q]
                        && dirty_q[fl_set_q][fl_way_q]) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {tag_q[fl_set_q][fl_way_q], fl_set_q};
                    mem_wdata_d = data_q[fl_set_q][fl_way_q];
                    state_d     = S_FL_WB;
                end else if (state_q == S_FL_SCAN || mem_req_ready) begin
                    if (state_q == S_FL_WB) begin
                        upd_en   = 1'b1;
                        upd_set  = fl_set_q;
                        upd_way  = fl_way_q;
                        upd_tag  = tag_q[fl_set_q][fl_way_q];
                        upd_data = data_q[fl_set_q][fl_way_q];
                    end
                    if (fl_last) begin
                        flush_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        state_d  = S_FL_SCAN;
                        fl_way_d = (fl_way_q == LAST_WAY) ? '0 : fl_way_q + 1'b1;
                        fl_set_d = (fl_way_q == LAST_WAY) ? fl_set_q + 1'b1 : fl_set_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age_q[s][w] <= WAY_W'(w);
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            vict_q       <= '0;
            fl_set_q     <= '0;
            fl_way_q     <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            flush_done_q <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            vict_q       <= vict_d;
            fl_set_q     <= fl_set_d;
            fl_way_q     <= fl_way_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            flush_done_q <= flush_done_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            if (upd_en) begin
                valid_q[upd_set][upd_way] <= 1'b1;
                dirty_q[upd_set][upd_way] <= upd_dirty;
            end
            // Accessed way becomes youngest; younger-than-it ways age by one.
            if (lru_en) begin
                for (int v = 0; v < WAYS; v++) begin
                    if (WAY_W'(v) == upd_way)
                        age_q[upd_set][v] <= '0;
                    else if (age_q[upd_set][v] < lru_old)
                        age_q[upd_set][v] <= age_q[upd_set][v] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (upd_en) begin
            tag_q[upd_set][upd_way]  <= upd_tag;
            data_q[upd_set][upd_way] <= upd_data;
        end
    end

    assign req_ready     = reset && (state_q == S_IDLE) && !flush;
    assign resp_hit      = (state_q == S_LOOKUP) && hit;
    assign resp_valid    = resp_hit || ((state_q == S_REFILL_WAIT) && mem_resp_valid);
    assign resp_rdata    = resp_hit ? data_q[idx][hit_way]
                         : (resp_valid ? (we_q ? wdata_q : mem_rdata) : '0);
    assign mem_req_valid = (state_q == S_WB) || (state_q == S_REFILL_REQ) || (state_q == S_FL_WB);
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign flush_done    = flush_done_q;
    assign hit_cnt       = hit_cnt_q;
    assign miss_cnt      = miss_cnt_q;
endmodule

// File: tb/tb_cache_l2_assoc.sv
module tb_cache_l2_assoc;
    logic        clk = 1'b0, reset = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_hit;
    logic [31:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready = 1'b1, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        flush = 1'b0, flush_done;
    logic [31:0] hit_cnt, miss_cnt;

    cache_l2_assoc dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .flush(flush), .flush_done(flush_done),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic hit; logic chk; logic [31:0] data; } resp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } mop_t;

    resp_t       sb[$];
    mop_t        exp_mem[$];
    logic [31:0] mem_arr [logic [31:0]];
    int          vectors = 0, miscompares = 0;
    int          resp_delay = 1, stall_left = 0, stall_seen = 0, fd_cnt = 0;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Response scoreboard and flush_done pulse counter.
    always @(negedge clk) begin
        if (flush_done === 1'b1) fd_cnt++;
        if (resp_valid === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL resp unexpected: hit=%b rdata=%h, wanted no response", resp_hit, resp_rdata);
            end else begin
                resp_t e;
                e = sb.pop_front();
                if (resp_hit !== e.hit || (e.chk && resp_rdata !== e.data)) begin
                    miscompares++;
                    $display("FAIL resp: hit=%b rdata=%h, wanted hit=%b rdata=%h", resp_hit, resp_rdata, e.hit, e.data);
                end
            end
        end
    end

    // Backing memory: checks each handshake against exp_mem, field stability while stalled.
    initial begin : mem_model
        logic        prev_pend, rd_pend, hs;
        logic [64:0] prev_f;
        logic [31:0] rd_addr;
        int          rd_cnt;
        prev_pend = 1'b0; rd_pend = 1'b0; prev_f = '0; rd_addr = '0; rd_cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_req_valid === 1'b1 && prev_pend) begin
                vectors++;
                if ({mem_we, mem_addr, mem_wdata} !== prev_f) begin
                    miscompares++;
                    $display("FAIL mem_stable: fields=%h, wanted %h", {mem_we, mem_addr, mem_wdata}, prev_f);
                end
            end
            if (mem_req_valid === 1'b1 && !mem_req_ready) stall_seen++;
            hs        = (mem_req_valid === 1'b1) && mem_req_ready;
            prev_pend = (mem_req_valid === 1'b1) && !mem_req_ready;
            prev_f    = {mem_we, mem_addr, mem_wdata};
            if (hs) begin
                vectors++;
                if (exp_mem.size() == 0) begin
                    miscompares++;
                    $display("FAIL mem_op unexpected: we=%b addr=%h data=%h, wanted none", mem_we, mem_addr, mem_wdata);
                end else begin
                    mop_t m;
                    m = exp_mem.pop_front();
                    if (mem_we !== m.we || mem_addr !== m.addr || (m.we && mem_wdata !== m.data)) begin
                        miscompares++;
                        $display("FAIL mem_op: we=%b addr=%h data=%h, wanted we=%b addr=%h data=%h",
                                 mem_we, mem_addr, mem_wdata, m.we, m.addr, m.data);
                    end
                end
                if (mem_we) mem_arr[mem_addr] = mem_wdata;
                else begin rd_pend = 1'b1; rd_cnt = resp_delay; rd_addr = mem_addr; end
            end
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
            if (rd_pend) begin
                if (rd_cnt <= 1) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata = mem_arr.exists(rd_addr) ? mem_arr[rd_addr] : pat(rd_addr);
                    rd_pend = 1'b0;
                end else rd_cnt--;
            end
            if (mem_req_valid === 1'b1 && mem_we === 1'b1 && stall_left > 0) begin
                mem_req_ready = 1'b0;
                stall_left--;
            end else mem_req_ready = 1'b1;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation still running, wanted completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic chk_hit);
        int n;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (!req_ready) begin
            vectors++; miscompares++;
            $display("FAIL req_accept addr=%h: req_ready=%b, wanted 1", a, req_ready);
        end
        @(posedge clk); #1 req_valid = 1'b0;
        if (chk_hit) begin
            @(negedge clk);
            vectors++;
            if (resp_valid !== 1'b1 || resp_hit !== 1'b1) begin
                miscompares++;
                $display("FAIL hit_latency addr=%h: resp_valid=%b hit=%b, wanted 1 1", a, resp_valid, resp_hit);
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || exp_mem.size() != 0) && n < 500) begin @(negedge clk); n++; end
        if (sb.size() != 0 || exp_mem.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL drain: %0d resp / %0d mem ops outstanding, wanted 0", sb.size(), exp_mem.size());
            sb.delete(); exp_mem.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_flush_done();
        int n;
        n = 0;
        while (fd_cnt == 0 && n < 3000) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        vectors++;
        if (fd_cnt !== 1) begin
            miscompares++;
            $display("FAIL flush_done pulses: %0d, wanted 1", fd_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({resp_valid, mem_req_valid, flush_done} !== 3'b000 || hit_cnt !== 0 || miss_cnt !== 0) begin
            miscompares++;
            $display("FAIL reset_outputs: rv=%b mv=%b fd=%b hc=%0d mc=%0d, wanted all 0",
                     resp_valid, mem_req_valid, flush_done, hit_cnt, miss_cnt);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: req_ready=%b, wanted 1", req_ready);
        end
    endtask

    task automatic test_cold_read();
        mem_arr[32'h1204] = 32'hDEAD_BEEF;
        exp_mem.push_back('{1'b0, 32'h1204, 32'h0});
        sb.push_back('{1'b0, 1'b1, 32'hDEAD_BEEF});
        do_req(1'b0, 32'h1204, 32'h0, 1'b0);
        wait_drain();
        sb.push_back('{1'b1, 1'b1, 32'hDEAD_BEEF});
        do_req(1'b0, 32'h1204, 32'h0, 1'b1);
        wait_drain();
        vectors++;
        if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1) begin
            miscompares++;
            $display("FAIL cold_counters: hit=%0d miss=%0d, wanted 1 1", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_evict();
        do_reset();
        exp_mem.push_back('{1'b0, 32'h004, 32'h0});
        sb.push_back('{1'b0, 1'b0, 32'h0});
        do_req(1'b1, 32'h004, 32'h11, 1'b0);
        exp_mem.push_back('{1'b0, 32'h204, 32'h0});
        sb.push_back('{1'b0, 1'b0, 32'h0});
        do_req(1'b1, 32'h204, 32'h22, 1'b0);
        exp_mem.push_back('{1'b1, 32'h004, 32'h11});
        exp_mem.push_back('{1'b0, 32'h404, 32'h0});
        sb.push_back('{1'b0, 1'b1, pat(32'h404)});
        do_req(1'b0, 32'h404, 32'h0, 1'b0);
        wait_drain();
        sb.push_back('{1'b1, 1'b1, 32'h22});
        do_req(1'b0, 32'h204, 32'h0, 1'b1);
        wait_drain();
        // 0x404 is now LRU and clean; refetching 0x004 sees the written-back value.
        exp_mem.push_back('{1'b0, 32'h004, 32'h0});
        sb.push_back('{1'b0, 1'b1, 32'h11});
        do_req(1'b0, 32'h004, 32'h0, 1'b0);
        wait_drain();
        vectors++;
        if (hit_cnt !== 32'd1 || miss_cnt !== 32'd4) begin
            miscompares++;
            $display("FAIL evict_counters: hit=%0d miss=%0d, wanted 1 4", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_wb_stall();
        do_reset();
        exp_mem.push_back('{1'b0, 32'h008, 32'h0});
        sb.push_back('{1'b0, 1'b0, 32'h0});
        do_req(1'b1, 32'h008, 32'hAA, 1'b0);
        exp_mem.push_back('{1'b0, 32'h208, 32'h0});
        sb.push_back('{1'b0, 1'b0, 32'h0});
        do_req(1'b1, 32'h208, 32'hBB, 1'b0);
        wait_drain();
        stall_left = 5;
        stall_seen = 0;
        exp_mem.push_back('{1'b1, 32'h008, 32'hAA});
        exp_mem.push_back('{1'b0, 32'h408, 32'h0});
        sb.push_back('{1'b0, 1'b1, pat(32'h408)});
        do_req(1'b0, 32'h408, 32'h0, 1'b0);
        wait_drain();
        vectors++;
        if (stall_seen !== 5) begin
            miscompares++;
            $display("FAIL wb_stall_cycles: %0d, wanted 5", stall_seen);
        end
        sb.push_back('{1'b1, 1'b1, 32'hBB});
        do_req(1'b0, 32'h208, 32'h0, 1'b1);
        wait_drain();
    endtask

    task automatic test_flush();
        do_reset();
        exp_mem.push_back('{1'b0, 32'h007, 32'h0});
        sb.push_back('{1'b0, 1'b0, 32'h0});
        do_req(1'b1, 32'h007, 32'h77, 1'b0);
        exp_mem.push_back('{1'b0, 32'h003, 32'h0});
        sb.push_back('{1'b0, 1'b0, 32'h0});
        do_req(1'b1, 32'h003, 32'h33, 1'b0);
        wait_drain();
        exp_mem.push_back('{1'b1, 32'h003, 32'h33});
        exp_mem.push_back('{1'b1, 32'h007, 32'h77});
        fd_cnt = 0;
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        wait_flush_done();
        vectors++;
        if (exp_mem.size() !== 0) begin
            miscompares++;
            $display("FAIL flush_writebacks: %0d outstanding, wanted 0", exp_mem.size());
            exp_mem.delete();
        end
        // Lines are now clean: a second flush must issue nothing.
        fd_cnt = 0;
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        wait_flush_done();
        sb.push_back('{1'b1, 1'b1, 32'h33});
        do_req(1'b0, 32'h003, 32'h0, 1'b1);
        wait_drain();
    endtask

    task automatic test_reset_refill();
        int n;
        do_reset();
        exp_mem.push_back('{1'b0, 32'h0B0, 32'h0});
        sb.push_back('{1'b0, 1'b1, pat(32'h0B0)});
        do_req(1'b0, 32'h0B0, 32'h0, 1'b0);
        wait_drain();
        resp_delay = 20;
        exp_mem.push_back('{1'b0, 32'h0A0, 32'h0});
        do_req(1'b0, 32'h0A0, 32'h0, 1'b0);
        n = 0;
        while (exp_mem.size() != 0 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (mem_req_valid !== 1'b0 || req_ready !== 1'b1 || exp_mem.size() != 0) begin
            miscompares++;
            $display("FAIL reset_abort: mem_req_valid=%b req_ready=%b pend=%0d, wanted 0 1 0",
                     mem_req_valid, req_ready, exp_mem.size());
            exp_mem.delete();
        end
        // The late memory return lands while idle and must be ignored.
        repeat (25) @(negedge clk);
        resp_delay = 1;
        exp_mem.push_back('{1'b0, 32'h0B0, 32'h0});
        sb.push_back('{1'b0, 1'b1, pat(32'h0B0)});
        do_req(1'b0, 32'h0B0, 32'h0, 1'b0);
        wait_drain();
    endtask

    task automatic test_flush_collision();
        logic seen_done;
        int   n;
        do_reset();
        fd_cnt = 0;
        seen_done = 1'b0;
        exp_mem.push_back('{1'b0, 32'h0C0, 32'h0});
        sb.push_back('{1'b0, 1'b1, pat(32'h0C0)});
        @(posedge clk); #1;
        flush = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0C0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL collision_ready: req_ready=%b, wanted 0", req_ready);
        end
        @(posedge clk); #1 flush = 1'b0;
        n = 0;
        @(negedge clk);
        while (n < 3000) begin
            if (flush_done === 1'b1) seen_done = 1'b1;
            if (req_ready === 1'b1) break;
            @(negedge clk);
            n++;
        end
        vectors++;
        if (seen_done !== 1'b1 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL collision_order: flush_done_seen=%b req_ready=%b, wanted 1 1", seen_done, req_ready);
        end
        @(posedge clk); #1 req_valid = 1'b0;
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_evict();
        test_wb_stall();
        test_flush();
        test_reset_refill();
        test_flush_collision();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cache_l2_assoc.md
CACHE_L2_ASSOC -- requirements
Module: cache_l2_assoc

Interface
REQ-001 SHALL have parameter WAYS, default 2, associativity; power of 2, 2..8.
REQ-002 SHALL have parameter SETS, default 512, set count; power of 2, >=2; IDX_W = log2(SETS).
REQ-003 SHALL have parameter ADDR_W, default 32, word-address width.
REQ-004 SHALL have parameter DATA_W, default 32, line/word width; one word per line.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-low reset (0 = reset).
REQ-007 SHALL have ports req_valid in 1, req_ready out 1, req_we in 1, req_addr in ADDR_W, req_wdata in DATA_W  core request channel.
REQ-008 SHALL have ports resp_valid out 1, resp_hit out 1, resp_rdata out DATA_W  one-cycle response, no backpressure.
REQ-009 SHALL have ports mem_req_valid out 1, mem_req_ready in 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W  backing-memory request.
REQ-010 SHALL have ports mem_resp_valid in 1, mem_rdata in DATA_W  memory read return.
REQ-011 SHALL have ports flush in 1, flush_done out 1  write-back-all command / completion pulse.
REQ-012 SHALL have ports hit_cnt out 32, miss_cnt out 32  wrapping performance counters.

Function
REQ-013 SHALL decode index = req_addr[IDX_W-1:0], tag = req_addr[ADDR_W-1:IDX_W]; no byte offset.
REQ-014 SHALL store per line: valid, dirty, tag, data, age (log2(WAYS) bits).
REQ-015 SHALL implement FSM IDLE, LOOKUP, WB, REFILL_REQ, REFILL_WAIT, FL_SCAN, FL_WB.
REQ-016 SHALL assert req_ready only in IDLE with flush low; request accepted on req_valid & req_ready, latched address/data/we.
REQ-017 SHALL, if flush and req_valid arrive together in IDLE, take flush and not accept the request.
REQ-018 SHALL, in LOOKUP on hit: read -> resp_rdata = line data; write -> line data = wdata, dirty = 1; resp_valid = 1, resp_hit = 1 in LOOKUP cycle (accept + 1); return to IDLE; hit_cnt += 1.
REQ-019 SHALL, in LOOKUP on miss, select victim = lowest-index invalid way, else way with age = WAYS-1; miss_cnt += 1.
REQ-020 SHALL go to WB if victim valid & dirty (mem_we = 1, mem_addr = {victim tag, index}, mem_wdata = victim data), else REFILL_REQ.
REQ-021 SHALL hold mem_req_valid and all mem_* fields stable until mem_req_ready; WB completes on handshake -> REFILL_REQ.
REQ-022 SHALL in REFILL_REQ issue read (mem_we = 0, mem_addr = request address); on handshake -> REFILL_WAIT.
REQ-023 SHALL on mem_resp_valid in REFILL_WAIT install line: valid = 1, tag; read: data = mem_rdata, dirty = 0, resp_rdata = mem_rdata; write: data = req wdata, dirty = 1 (write-allocate); resp_valid = 1, resp_hit = 0; -> IDLE.
REQ-024 SHALL ignore mem_resp_valid outside REFILL_WAIT.
REQ-025 SHALL update LRU on every hit/install: accessed way age = 0; ways in set with age < old accessed age increment; others unchanged; ages in a set remain a permutation of 0..WAYS-1.
REQ-026 SHALL on flush walk sets 0..SETS-1, ways 0..WAYS-1 ascending; each valid & dirty line written back via FL_WB (same handshake as WB), then dirty = 0, valid kept.
REQ-027 SHALL pulse flush_done one cycle after last line processed, then return to IDLE; flush while not IDLE is ignored.
REQ-028 SHALL let hit_cnt/miss_cnt wrap 0xFFFFFFFF -> 0.
REQ-029 SHALL keep resp_valid, flush_done low in all cycles other than those specified.

Reset
REQ-030 SHALL on reset = 0 at a rising edge: all valid/dirty = 0, age[w] = w, state = IDLE, counters = 0, all outputs 0 except req_ready (1 when reset released and flush low); mem_req_valid drops immediately, aborting any transaction in progress.
REQ-031 SHALL clear tag/data storage values optionally; they are not observable while valid = 0.

Verification
REQ-032 Read 0x0000_1204 cold -> mem read addr 0x1204; return 0xDEADBEEF -> resp_valid, hit=0, rdata 0xDEADBEEF; repeat read -> resp at accept+1, hit=1, miss_cnt=1, hit_cnt=1.
REQ-033 WAYS=2: write 0x004 data 0x11, write 0x204 data 0x22, read 0x404 -> mem write addr 0x004 data 0x11 precedes mem read addr 0x404; 0x204 stays resident (hit).
REQ-034 mem_req_ready held low 5 cycles during WB -> mem_* fields stable throughout, single write on handshake.
REQ-035 Two dirty lines (sets 3, 7) then flush -> writebacks in order set 3 then set 7, flush_done one pulse, second flush issues no mem requests.
REQ-036 Reset asserted during REFILL_WAIT -> next cycle mem_req_valid=0, req_ready=1 after release, prior line absent (read misses).
REQ-037 flush and req_valid same IDLE cycle -> flush taken, req_ready=0, request accepted only after flush_done.
